board_io_conditioner: RTL and testbench

BOARD_IO_CONDITIONER -- requirements
Module: board_io_conditioner

---
 rtl/board_io_conditioner.sv | 116 +++++++++++
 tb/tb_board_io_conditioner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_conditioner.sv
// Board input conditioning: 2-flop synchronizers, per-input debounce, and a
// button-driven reset-hold FSM producing a glitch-free active-low core reset.
//
// state  | meaning
// S_IDLE | core running, cpu_rst_n = 1
// S_HOLD | core held in reset, cpu_rst_n = 0, hold_cnt counts down
module board_io_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int RST_HOLD        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw_raw,
    input  logic        btn_raw,
    output logic [15:0] sw_stable,
    output logic [15:0] sw_changed,
    output logic        btn_stable,
    output logic        btn_press,
    output logic        cpu_rst_n
);
    localparam int N  = 17;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_HOLD);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    logic [N-1:0]  sync_a;
    logic [N-1:0]  syn;
    logic [N-1:0]  stable;
    logic [N-1:0]  pulse;
    logic [CW-1:0] cnt [N];

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;

    // Bit 16 carries the button; bits 15:0 the switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= '0;
            syn    <= '0;
        end else begin
            sync_a <= {btn_raw, sw_raw};
            syn    <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stable <= '0;
            pulse  <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                pulse[i] <= 1'b0;
                if (syn[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= syn[i];
                    cnt[i]    <= '0;
                    // Switches pulse on any update; the button only on press.
                    pulse[i]  <= (i < 16) ? 1'b1 : syn[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign sw_stable  = stable[15:0];
    assign sw_changed = pulse[15:0];
    assign btn_stable = stable[16];
    assign btn_press  = pulse[16];

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            S_IDLE: begin
                if (btn_press) begin
                    state_nxt = S_HOLD;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            S_HOLD: begin
                // A fresh press extends the hold rather than ending it.
                if (btn_press) begin
                    hold_nxt = HOLD_LOAD;
                end else if (hold_cnt == HW'(1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    hold_nxt = hold_cnt - HW'(1);
                end
            end
            default: state_nxt = S_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HOLD;
            hold_cnt  <= HOLD_LOAD;
            cpu_rst_n <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            cpu_rst_n <= (state_nxt == S_IDLE);
        end
    end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Scoreboard bench: stimulus pushes expected output events per channel with
// the cycle they must appear; a negedge monitor pops and compares them.
module tb_board_io_conditioner;
    localparam int DEB    = 4;
    localparam int HOLD   = 3;
    localparam int HOLD_L = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_raw;
    logic        btn_raw;
    logic [15:0] sw_stable, sw_changed;
    logic        btn_stable, btn_press, cpu_rst_n;
    logic [15:0] sw_stable_l, sw_changed_l;
    logic        btn_stable_l, btn_press_l, cpu_rst_n_l;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    ev_t sw_q[$];
    ev_t bp_q[$];
    ev_t bs_q[$];
    ev_t rp_q[$];
    ev_t rl_q[$];

    board_io_conditioner #(.DEBOUNCE_CYCLES(DEB), .RST_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw),
        .sw_stable(sw_stable), .sw_changed(sw_changed),
        .btn_stable(btn_stable), .btn_press(btn_press), .cpu_rst_n(cpu_rst_n)
    );

    // Longer hold instance, so a second press can land inside an active hold.
    board_io_conditioner #(.DEBOUNCE_CYCLES(DEB), .RST_HOLD(HOLD_L)) dut_l (
        .clk(clk), .rst(rst), .sw_raw(sw_raw), .btn_raw(btn_raw),
        .sw_stable(sw_stable_l), .sw_changed(sw_changed_l),
        .btn_stable(btn_stable_l), .btn_press(btn_press_l), .cpu_rst_n(cpu_rst_n_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic score(input string name, input bit have, input ev_t e,
                         input logic [15:0] a, input logic [15:0] b);
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL %s unexpected event at cycle %0d a=%h b=%h", name, cyc, a, b);
        end else if (e.cyc != cyc || e.a !== a || e.b !== b) begin
            errors++;
            $display("FAIL %s got cycle %0d a=%h b=%h, expected cycle %0d a=%h b=%h",
                     name, cyc, a, b, e.cyc, e.a, e.b);
        end
    endtask

    logic [15:0] p_sw = '0;
    logic        p_bs = 1'b0;
    logic        p_rp = 1'b0;
    logic        p_rl = 1'b0;

    always @(negedge clk) begin
        ev_t e;
        bit  have;
        if (cyc >= 1) begin
            if (sw_changed != 16'h0 || sw_stable != p_sw) begin
                e = '{0, '0, '0};
                have = sw_q.size() > 0;
                if (have) e = sw_q.pop_front();
                score("sw_event", have, e, sw_changed, sw_stable);
            end
            if (btn_press) begin
                e = '{0, '0, '0};
                have = bp_q.size() > 0;
                if (have) e = bp_q.pop_front();
                score("btn_press", have, e, 16'(btn_press), 16'h0);
            end
            if (btn_stable != p_bs) begin
                e = '{0, '0, '0};
                have = bs_q.size() > 0;
                if (have) e = bs_q.pop_front();
                score("btn_stable", have, e, 16'(btn_stable), 16'h0);
            end
            if (cpu_rst_n != p_rp) begin
                e = '{0, '0, '0};
                have = rp_q.size() > 0;
                if (have) e = rp_q.pop_front();
                score("cpu_rst_n", have, e, 16'(cpu_rst_n), 16'h0);
            end
            if (cpu_rst_n_l != p_rl) begin
                e = '{0, '0, '0};
                have = rl_q.size() > 0;
                if (have) e = rl_q.pop_front();
                score("cpu_rst_n_long", have, e, 16'(cpu_rst_n_l), 16'h0);
            end
            p_sw = sw_stable;
            p_bs = btn_stable;
            p_rp = cpu_rst_n;
            p_rl = cpu_rst_n_l;
        end
    end

    // ch: 0 sw, 1 btn_press, 2 btn_stable, 3 cpu_rst_n, 4 long-hold cpu_rst_n
    task automatic push(input int ch, input int c, input logic [15:0] a, input logic [15:0] b);
        ev_t e;
        e = '{c, a, b};
        case (ch)
            0: sw_q.push_back(e);
            1: bp_q.push_back(e);
            2: bs_q.push_back(e);
            3: rp_q.push_back(e);
            default: rl_q.push_back(e);
        endcase
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string name);
        checks++;
        if ({sw_stable, sw_changed, btn_stable, btn_press, cpu_rst_n,
             sw_stable_l, sw_changed_l, btn_stable_l, btn_press_l, cpu_rst_n_l} !== '0) begin
            errors++;
            $display("FAIL %s outputs not all zero: sw_stable=%h sw_changed=%h btn_stable=%b btn_press=%b cpu_rst_n=%b long_rst_n=%b",
                     name, sw_stable, sw_changed, btn_stable, btn_press, cpu_rst_n, cpu_rst_n_l);
        end
    endtask

    task automatic drain(input string name, inout ev_t q[$]);
        while (q.size() > 0) begin
            ev_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing event: expected cycle %0d a=%h b=%h", name, e.cyc, e.a, e.b);
        end
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        sw_raw  = 16'h0;
        btn_raw = 1'b0;

        // Reset for two cycles; power-on hold follows release.
        step(1);
        check_reset("reset_cycle1");
        step(1);
        check_reset("reset_cycle2");
        n = cyc;
        push(3, n + HOLD, 16'h1, 16'h0);
        push(4, n + HOLD_L, 16'h1, 16'h0);
        rst = 1'b0;
        step(20);

        // Two switches change together.
        n = cyc;
        sw_raw = 16'h8001;
        push(0, n + DEB + 2, 16'h8001, 16'h8001);
        step(10);

        // Glitch on bit 3 lasting DEB-1 synchronized cycles: no event.
        sw_raw = 16'h8009;
        step(3);
        sw_raw = 16'h8001;
        step(12);
        checks++;
        if (sw_stable !== 16'h8001) begin
            errors++;
            $display("FAIL glitch_sw_stable got %h expected %h", sw_stable, 16'h8001);
        end

        // Single press from idle, then release.
        n = cyc;
        btn_raw = 1'b1;
        push(1, n + 6, 16'h1, 16'h0);
        push(2, n + 6, 16'h1, 16'h0);
        push(3, n + 7, 16'h0, 16'h0);
        push(3, n + 7 + HOLD, 16'h1, 16'h0);
        push(4, n + 7, 16'h0, 16'h0);
        push(4, n + 7 + HOLD_L, 16'h1, 16'h0);
        step(25);
        n = cyc;
        btn_raw = 1'b0;
        push(2, n + 6, 16'h0, 16'h0);
        step(10);

        // Press, release, press again: second press lands inside the long hold.
        n = cyc;
        btn_raw = 1'b1;
        push(1, n + 6, 16'h1, 16'h0);
        push(2, n + 6, 16'h1, 16'h0);
        push(3, n + 7, 16'h0, 16'h0);
        push(3, n + 7 + HOLD, 16'h1, 16'h0);
        push(4, n + 7, 16'h0, 16'h0);
        step(6);
        btn_raw = 1'b0;
        push(2, n + 12, 16'h0, 16'h0);
        step(6);
        btn_raw = 1'b1;
        push(1, n + 18, 16'h1, 16'h0);
        push(2, n + 18, 16'h1, 16'h0);
        push(3, n + 19, 16'h0, 16'h0);
        push(3, n + 19 + HOLD, 16'h1, 16'h0);
        push(4, n + 19 + HOLD_L, 16'h1, 16'h0);
        step(6);
        btn_raw = 1'b0;
        push(2, n + 24, 16'h0, 16'h0);
        step(22);

        // Switches back to zero.
        n = cyc;
        sw_raw = 16'h0000;
        push(0, n + 6, 16'h8001, 16'h0000);
        step(10);

        // Reset lands when the bit-1 counter sits at DEB-1.
        n = cyc;
        sw_raw = 16'h0002;
        step(5);
        rst = 1'b1;
        push(3, n + 6, 16'h0, 16'h0);
        push(4, n + 6, 16'h0, 16'h0);
        step(1);
        check_reset("reset_mid_debounce");
        step(1);
        check_reset("reset_mid_debounce2");
        n = cyc;
        rst = 1'b0;
        push(3, n + HOLD, 16'h1, 16'h0);
        push(4, n + HOLD_L, 16'h1, 16'h0);
        push(0, n + 6, 16'h0002, 16'h0002);
        step(24);

        drain("sw_event", sw_q);
        drain("btn_press", bp_q);
        drain("btn_stable", bs_q);
        drain("cpu_rst_n", rp_q);
        drain("cpu_rst_n_long", rl_q);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
